// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART bootloader that streams framed bytes into the imem/dmem programming port.
//   clk        loader clock, also forwarded as the memory write clock
//   rstn       asynchronous active-low reset
//   rx_i       UART RX line (asynchronous, idles high)
//   upg_clk_o  memory write clock (= clk)
//   upg_wen_o  one-cycle write strobe
//   upg_adr_o  [14]=target (0 imem, 1 dmem), [13:0]=word address
//   upg_dat_o  write data (little-endian assembled word)
//   upg_done_o programming finished, sticky until reset
//   busy_o     frame in progress
//   err_o      sticky error: framing, bad header, bad count or timeout
module uart_prog_loader #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_i,
    output logic        upg_clk_o,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, CNT0, CNT1, DATA, DONE} state_t;

    rx_state_t      r_rx_state, w_rx_next;
    logic [1:0]     r_sync;
    logic           r_rx_d;
    logic [CW-1:0]  r_clk_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_rx_byte;
    logic           w_rx, w_bit_end, w_byte_vld, w_frm_err;

    state_t         r_state, w_next;
    logic           r_tgt, r_wen, r_done, r_err;
    logic [7:0]     r_cnt_l;
    logic [15:0]    r_n;
    logic [13:0]    r_addr;
    logic [1:0]     r_idx;
    logic [23:0]    r_word;
    logic [14:0]    r_adr;
    logic [31:0]    r_dat;
    logic [TW-1:0]  r_to_cnt;
    logic [15:0]    w_cnt;
    logic           w_busy, w_set_err, w_word_done, w_last, w_to;

    assign w_rx      = r_sync[1];
    assign w_bit_end = r_clk_cnt == C_LAST;

    // Start bit is checked at its centre so a short low glitch is rejected silently.
    always_comb begin
        w_rx_next  = r_rx_state;
        w_byte_vld = 1'b0;
        w_frm_err  = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_d && !w_rx) w_rx_next = RX_START;
            RX_START: if (r_clk_cnt == C_HALF) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (w_bit_end) begin
                    w_rx_next  = RX_IDLE;
                    w_byte_vld = w_rx;
                    w_frm_err  = !w_rx;
                end
            end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync     <= 2'b11;
            r_rx_d     <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_byte  <= '0;
        end else begin
            r_sync     <= {r_sync[0], rx_i};
            r_rx_d     <= w_rx;
            r_rx_state <= w_rx_next;
            r_clk_cnt  <= (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_bit_end) ? '0 : r_clk_cnt + 1'b1;
            if (r_rx_state == RX_DATA && w_bit_end) begin
                r_rx_byte <= {w_rx, r_rx_byte[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    assign w_cnt       = {r_rx_byte, r_cnt_l};
    assign w_busy      = r_state == CNT0 || r_state == CNT1 || r_state == DATA;
    assign w_word_done = r_state == DATA && w_byte_vld && r_idx == 2'd3;
    assign w_last      = {2'b00, r_addr} == r_n - 16'd1;
    assign w_to        = r_to_cnt == T_MAX;

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_byte_vld) begin
                    if (r_rx_byte == 8'hFF) w_next = DONE;
                    else if (r_rx_byte == 8'hA5 || r_rx_byte == 8'h5A) w_next = CNT0;
                    else w_set_err = 1'b1;
                end
            end
            CNT0: if (w_byte_vld) w_next = CNT1;
            CNT1: begin
                if (w_byte_vld) begin
                    w_set_err = w_cnt == 16'd0 || w_cnt > 16'd16384;
                    w_next    = w_set_err ? IDLE : DATA;
                end
            end
            DATA: if (w_word_done && w_last) w_next = IDLE;
            DONE: w_next = DONE;
            default: w_next = IDLE;
        endcase
        // Line faults and stalls abandon the frame; a partial word is simply never written.
        if (r_state != DONE && w_frm_err) w_set_err = 1'b1;
        if (w_busy && (w_frm_err || w_to)) begin
            w_set_err = 1'b1;
            w_next    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_tgt    <= 1'b0;
            r_wen    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt_l  <= '0;
            r_n      <= '0;
            r_addr   <= '0;
            r_idx    <= '0;
            r_word   <= '0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_err    <= r_err | w_set_err;
            r_done   <= r_done | (w_next == DONE);
            r_wen    <= w_word_done;
            r_to_cnt <= (w_busy && !w_byte_vld && w_next == r_state) ? r_to_cnt + 1'b1 : '0;
            if (w_byte_vld) begin
                case (r_state)
                    IDLE: r_tgt <= r_rx_byte == 8'h5A;
                    CNT0: r_cnt_l <= r_rx_byte;
                    CNT1: begin
                        r_n    <= w_cnt;
                        r_addr <= '0;
                        r_idx  <= '0;
                    end
                    DATA: begin
                        r_word <= {r_rx_byte, r_word[23:8]};
                        r_idx  <= r_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            // The fourth byte goes straight into the output word; the first three sit in r_word.
            if (w_word_done) begin
                r_adr  <= {r_tgt, r_addr};
                r_dat  <= {r_rx_byte, r_word};
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign upg_clk_o  = clk;
    assign upg_wen_o  = r_wen;
    assign upg_adr_o  = r_adr;
    assign upg_dat_o  = r_dat;
    assign upg_done_o = r_done;
    assign busy_o     = w_busy;
    assign err_o      = r_err;
endmodule
